// File: rtl/regcla_addsub_seq.sv
// Keypad-fed W-bit add/subtract unit: grouped carry-lookahead adder, submit/done FSM, ZNVC flags.
// Latency: result, flags and done valid 2 edges after submit is accepted; digits visible 1 edge after entry.
// Backpressure: none; key_valid and submit are dropped (not queued) while busy; submit beats key_valid in IDLE.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset (clears everything, aborts a calc)
//   key_in, key_valid   - hex digit strobe, shifted into A (load_sel=0) or B (load_sel=1) while idle
//   addsub, acc, submit - operation request; addsub/acc captured when submit is accepted in IDLE
//   a_out, b_out        - operand registers
//   r_out, cc_out       - registered result and {Z,N,V,C}
//   r_mag, r_sign       - sign/magnitude view of r_out (combinational)
//   busy, done          - busy in CALC/DONE, done pulses for the cycle r_out/cc_out are fresh
module regcla_addsub_seq #(
    parameter int W     = 8,
    parameter int GROUP = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   key_in,
    input  logic         key_valid,
    input  logic         load_sel,
    input  logic         addsub,
    input  logic         acc,
    input  logic         submit,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic [W-1:0] r_out,
    output logic [W-1:0] r_mag,
    output logic         r_sign,
    output logic [3:0]   cc_out,
    output logic         busy,
    output logic         done
);

    localparam int NG = W / GROUP;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic         take_key;
    logic         take_submit;
    logic         commit;

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] r_q, r_d;
    logic [3:0]   cc_q, cc_d;
    logic         sub_q, sub_d;
    logic         acc_q, acc_d;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (submit) state_d = S_CALC;
            S_CALC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs and datapath enables
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        take_submit = (state_q == S_IDLE) && submit;
        // A digit arriving with submit is discarded so the calc sees pre-cycle operands.
        take_key    = (state_q == S_IDLE) && key_valid && !submit;
        commit      = (state_q == S_CALC);
    end

    // ------------------------------------------------------------------
    // Grouped carry-lookahead adder: full lookahead inside each GROUP-bit
    // block, block carry-out ripples into the next block.
    // ------------------------------------------------------------------
    logic [W-1:0] b_eff;
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;
    logic [W-1:0] sum;

    assign b_eff = b_q ^ {W{sub_q}};
    assign p     = a_q ^ b_eff;
    assign g     = a_q & b_eff;

    always_comb begin : cla_carry
        logic cin_grp;
        logic t;
        logic term;
        c       = '0;
        cin_grp = sub_q;
        t       = 1'b0;
        term    = 1'b0;
        c[0]    = sub_q;
        for (int gi = 0; gi < NG; gi++) begin
            for (int j = 1; j <= GROUP; j++) begin
                // Carry into bit j of the block: block carry-in propagated
                // through bits 0..j-1, or any generate k propagated to j.
                t = cin_grp;
                for (int k = 0; k < j; k++) begin
                    t = t & p[gi*GROUP + k];
                end
                for (int k = 0; k < j; k++) begin
                    term = g[gi*GROUP + k];
                    for (int m = k + 1; m < j; m++) begin
                        term = term & p[gi*GROUP + m];
                    end
                    t = t | term;
                end
                c[gi*GROUP + j] = t;
            end
            cin_grp = c[gi*GROUP + GROUP];
        end
    end

    assign sum = p ^ c[W-1:0];

    logic flag_z, flag_n, flag_v, flag_c;

    assign flag_z = (sum == '0);
    assign flag_n = sum[W-1];
    assign flag_v = (a_q[W-1] == b_eff[W-1]) && (sum[W-1] != a_q[W-1]);
    assign flag_c = c[W];

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        r_d   = r_q;
        cc_d  = cc_q;
        sub_d = sub_q;
        acc_d = acc_q;
        // Shifting left by a nibble drops the oldest digit; no overflow case.
        if (take_key) begin
            if (load_sel) begin
                b_d = (b_q << 4) | W'(key_in);
            end else begin
                a_d = (a_q << 4) | W'(key_in);
            end
        end
        if (take_submit) begin
            sub_d = addsub;
            acc_d = acc;
        end
        if (commit) begin
            r_d  = sum;
            cc_d = {flag_z, flag_n, flag_v, flag_c};
            if (acc_q) begin
                a_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            cc_q  <= '0;
            sub_q <= 1'b0;
            acc_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            r_q   <= r_d;
            cc_q  <= cc_d;
            sub_q <= sub_d;
            acc_q <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_out  = a_q;
    assign b_out  = b_q;
    assign r_out  = r_q;
    assign cc_out = cc_q;
    assign r_sign = r_q[W-1];
    // Two's-complement negate; the most negative value maps to itself,
    // which read unsigned is exactly 2^(W-1).
    assign r_mag  = r_q[W-1] ? ('0 - r_q) : r_q;

endmodule

// File: tb/tb_regcla_addsub_seq.sv
module tb_regcla_addsub_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_in;
    logic       key_valid;
    logic       load_sel;
    logic       addsub;
    logic       acc;
    logic       submit;
    logic [7:0] a_out, b_out, r_out, r_mag;
    logic       r_sign;
    logic [3:0] cc_out;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    // Reference operand values, tracked from the digit-entry rule.
    logic [7:0] a_m, b_m;

    always #5 clk = ~clk;

    regcla_addsub_seq #(.W(8), .GROUP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .key_valid (key_valid),
        .load_sel  (load_sel),
        .addsub    (addsub),
        .acc       (acc),
        .submit    (submit),
        .a_out     (a_out),
        .b_out     (b_out),
        .r_out     (r_out),
        .r_mag     (r_mag),
        .r_sign    (r_sign),
        .cc_out    (cc_out),
        .busy      (busy),
        .done      (done)
    );

    // Drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic. Returns {Z,N,V,C, result}.
    function automatic logic [11:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int ua, ub, ures, sa, sb, sres;
        logic [7:0] r;
        logic z, n, v, cy;
        ua   = int'(a);
        ub   = int'(b);
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        ures = sub ? (ua + 256 - ub) : (ua + ub);
        sres = sub ? (sa - sb) : (sa + sb);
        r    = ures[7:0];
        cy   = (ures > 255);
        v    = (sres > 127) || (sres < -128);
        z    = (r == 8'h00);
        n    = (sres < 0) ^ v;
        return {z, n, v, cy, r};
    endfunction

    function automatic logic [7:0] ref_mag(input logic [7:0] r);
        int m;
        m = r[7] ? (256 - int'(r)) : int'(r);
        return m[7:0];
    endfunction

    task automatic press(input logic sel, input logic [3:0] d);
        load_sel  = sel;
        key_in    = d;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        if (sel) b_m = {b_m[3:0], d};
        else     a_m = {a_m[3:0], d};
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        press(1'b0, a[7:4]);
        press(1'b0, a[3:0]);
        press(1'b1, b[7:4]);
        press(1'b1, b[3:0]);
    endtask

    // Issue one submit and wait (bounded) for done; cyc = edges from submit to done.
    task automatic calc(input logic sub, input logic ac, output int cyc);
        addsub = sub;
        acc    = ac;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        cyc    = 1;
        while (done !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int dones;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({a_out, b_out, r_out, cc_out, busy, done} !== 30'h0) begin
            errors++;
            $display("FAIL reset_init: got a=%h b=%h r=%h cc=%b busy=%b done=%b, want all 0",
                     a_out, b_out, r_out, cc_out, busy, done);
        end
        // Random activity, then reset asserted while inputs are still active.
        for (int i = 0; i < 12; i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_in    = 4'($urandom);
            load_sel  = 1'($urandom_range(0, 1));
            addsub    = 1'($urandom_range(0, 1));
            acc       = 1'($urandom_range(0, 1));
            submit    = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        key_valid = 1'b0;
        submit    = 1'b0;
        acc       = 1'b0;
        checks++;
        if ({a_out, b_out, r_out, cc_out, busy, done} !== 30'h0) begin
            errors++;
            $display("FAIL reset_mid_activity: got a=%h b=%h r=%h cc=%b busy=%b done=%b, want all 0",
                     a_out, b_out, r_out, cc_out, busy, done);
        end
        a_m = 8'h00;
        b_m = 8'h00;
        // Abort a calculation in CALC.
        load_ab(8'h12, 8'h34);
        addsub = 1'b0;
        acc    = 1'b1;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: got busy=%b, want 1", busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acc   = 1'b0;
        checks++;
        if ({r_out, cc_out, a_out, busy, done} !== 22'h0) begin
            errors++;
            $display("FAIL abort_state: got r=%h cc=%b a=%h busy=%b done=%b, want all 0",
                     r_out, cc_out, a_out, busy, done);
        end
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
        end
        a_m = 8'h00;
        b_m = 8'h00;
    endtask

    task automatic test_add();
        int cyc;
        load_ab(8'h3C, 8'h15);
        calc(1'b0, 1'b0, cyc);
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL add_latency: got %0d edges to done, want 2", cyc);
        end
        checks++;
        if ({a_out, b_out} !== 16'h3C15) begin
            errors++;
            $display("FAIL add_operands: got a=%h b=%h, want a=3c b=15", a_out, b_out);
        end
        checks++;
        if ({r_out, cc_out} !== {8'h51, 4'b0000}) begin
            errors++;
            $display("FAIL add_result: got r=%h cc=%b, want r=51 cc=0000", r_out, cc_out);
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL add_release: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_sub_negative();
        int cyc;
        load_ab(8'h15, 8'h3C);
        calc(1'b1, 1'b0, cyc);
        checks++;
        if ({r_out, cc_out} !== {8'hD9, 4'b0100}) begin
            errors++;
            $display("FAIL sub_neg_result: got r=%h cc=%b, want r=d9 cc=0100", r_out, cc_out);
        end
        checks++;
        if ({r_sign, r_mag} !== {1'b1, 8'h27}) begin
            errors++;
            $display("FAIL sub_neg_signmag: got sign=%b mag=%h, want sign=1 mag=27", r_sign, r_mag);
        end
        tick();
    endtask

    task automatic test_extremes();
        logic [7:0] ta  [3] = '{8'h7F, 8'hFF, 8'h3C};
        logic [7:0] tb  [3] = '{8'h01, 8'h01, 8'h3C};
        logic       ts  [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] tr  [3] = '{8'h80, 8'h00, 8'h00};
        logic [3:0] tc  [3] = '{4'b0110, 4'b1001, 4'b1001};
        logic [7:0] tm  [3] = '{8'h80, 8'h00, 8'h00};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            load_ab(ta[i], tb[i]);
            calc(ts[i], 1'b0, cyc);
            checks++;
            if ({r_out, cc_out, r_mag} !== {tr[i], tc[i], tm[i]}) begin
                errors++;
                $display("FAIL extreme_%0d: got r=%h cc=%b mag=%h, want r=%h cc=%b mag=%h",
                         i, r_out, cc_out, r_mag, tr[i], tc[i], tm[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int cyc;
        int nd;
        logic sub, ac;
        logic [11:0] exp;
        for (int i = 0; i < 24; i++) begin
            nd = $urandom_range(0, 4);
            for (int d = 0; d < nd; d++) begin
                press(1'($urandom_range(0, 1)), 4'($urandom));
            end
            sub = 1'($urandom_range(0, 1));
            ac  = 1'($urandom_range(0, 1));
            exp = ref_op(a_m, b_m, sub);
            calc(sub, ac, cyc);
            checks++;
            if (cyc != 2 || {cc_out, r_out} !== exp) begin
                errors++;
                $display("FAIL rand_%0d: a=%h b=%h sub=%b got r=%h cc=%b after %0d edges, want r=%h cc=%b after 2",
                         i, a_m, b_m, sub, r_out, cc_out, cyc, exp[7:0], exp[11:8]);
            end
            checks++;
            if ({r_sign, r_mag} !== {exp[7], ref_mag(exp[7:0])}) begin
                errors++;
                $display("FAIL rand_signmag_%0d: got sign=%b mag=%h, want sign=%b mag=%h",
                         i, r_sign, r_mag, exp[7], ref_mag(exp[7:0]));
            end
            if (ac) a_m = exp[7:0];
            tick();
            checks++;
            if ({a_out, b_out} !== {a_m, b_m}) begin
                errors++;
                $display("FAIL rand_operands_%0d: got a=%h b=%h, want a=%h b=%h", i, a_out, b_out, a_m, b_m);
            end
        end
        acc = 1'b0;
    endtask

    task automatic test_accumulate();
        int pulses;
        load_ab(8'h10, 8'h01);
        pulses = 0;
        addsub = 1'b0;
        acc    = 1'b1;
        submit = 1'b1;
        for (int i = 0; i < 9; i++) begin
            key_valid = busy;
            key_in    = 4'hF;
            load_sel  = 1'($urandom_range(0, 1));
            tick();
            if (done === 1'b1) begin
                pulses++;
                checks++;
                if (a_out !== 8'(8'h10 + pulses)) begin
                    errors++;
                    $display("FAIL acc_step_%0d: got a=%h, want %h", pulses, a_out, 8'(8'h10 + pulses));
                end
            end
        end
        submit    = 1'b0;
        key_valid = 1'b0;
        acc       = 1'b0;
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL acc_pulses: got %0d done pulses, want 3", pulses);
        end
        checks++;
        if ({a_out, b_out, busy} !== {8'h13, 8'h01, 1'b0}) begin
            errors++;
            $display("FAIL acc_final: got a=%h b=%h busy=%b, want a=13 b=01 busy=0", a_out, b_out, busy);
        end
        a_m = 8'h13;
        b_m = 8'h01;
    endtask

    task automatic test_collision();
        int cyc;
        load_ab(8'h22, 8'h11);
        load_sel  = 1'b0;
        key_in    = 4'h7;
        key_valid = 1'b1;
        addsub    = 1'b0;
        acc       = 1'b0;
        submit    = 1'b1;
        tick();
        key_valid = 1'b0;
        submit    = 1'b0;
        cyc       = 1;
        while (done !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 2 || r_out !== 8'h33) begin
            errors++;
            $display("FAIL collision_result: got r=%h after %0d edges, want r=33 after 2", r_out, cyc);
        end
        checks++;
        if (a_out !== 8'h22) begin
            errors++;
            $display("FAIL collision_a: got a=%h, want 22", a_out);
        end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        key_in    = 4'h0;
        key_valid = 1'b0;
        load_sel  = 1'b0;
        addsub    = 1'b0;
        acc       = 1'b0;
        submit    = 1'b0;
        a_m       = 8'h00;
        b_m       = 8'h00;
        test_reset();
        test_add();
        test_sub_negative();
        test_extremes();
        test_random();
        test_accumulate();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
